// File: rtl/alu_regfile_if.sv
// alu_regfile_if: register-file ports and ALU operand/result bundle
// master = CPU top level, slave = alu_regfile
interface alu_regfile_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic [AW-1:0]   raddr1;
  logic [XLEN-1:0] rdata1;
  logic [AW-1:0]   raddr2;
  logic [XLEN-1:0] rdata2;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] alu_src1;
  logic [XLEN-1:0] alu_src2;
  logic [1:0]      aluop;
  logic [XLEN-1:0] alu_result;

  modport master (
    output raddr1, raddr2,
    output we, waddr, wdata,
    output alu_src1, alu_src2, aluop,
    input  rdata1, rdata2, alu_result
  );

  modport slave (
    input  raddr1, raddr2,
    input  we, waddr, wdata,
    input  alu_src1, alu_src2, aluop,
    output rdata1, rdata2, alu_result
  );
endinterface

// File: rtl/alu_regfile.sv
// alu_regfile: 32x64 integer register file (x0 = 0) plus
// add / unsigned set-less-than ALU for the execute datapath
module alu_regfile #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input logic         clk,
  input logic         rst,
  alu_regfile_if.slave bus
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [XLEN-1:0] w_add;
  logic            w_ltu;
  logic [XLEN-1:0] w_result;

  // sync clear on reset; otherwise write port, x0 discarded
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (bus.we && bus.waddr != '0) begin
      r_regs[bus.waddr] <= bus.wdata;
    end
  end

  // reads see stored state only: no same-cycle bypass
  assign bus.rdata1 = (bus.raddr1 == '0) ? '0
                    : r_regs[bus.raddr1];
  assign bus.rdata2 = (bus.raddr2 == '0) ? '0
                    : r_regs[bus.raddr2];

  assign w_add = bus.alu_src1 + bus.alu_src2;
  assign w_ltu = bus.alu_src1 < bus.alu_src2;

  // op select; 00 and illegal 11 both yield zero
  always_comb begin
    w_result = '0;
    case (bus.aluop)
      2'b01:   w_result = w_add;
      2'b10:   w_result = {{(XLEN-1){1'b0}}, w_ltu};
      default: w_result = '0;
    endcase
  end

  assign bus.alu_result = w_result;

endmodule

// File: tb/tb_alu_regfile.sv
// tb_alu_regfile: ALU vector table plus register-file
// sequences, checked through an expected-value queue
module tb_alu_regfile;

  typedef struct {
    string       name;
    logic [63:0] exp;
  } exp_t;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  alu_regfile_if #(.XLEN(64), .NREG(32)) bus ();

  alu_regfile #(.XLEN(64), .NREG(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [63:0] model [32];

  task automatic push(input string n, input logic [63:0] e);
    exp_t t;
    t.name = n;
    t.exp  = e;
    sb.push_back(t);
  endtask

  task automatic pop_cmp(input logic [63:0] act);
    exp_t t;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty act=%h", act);
    end else begin
      t = sb.pop_front();
      if (act !== t.exp) begin
        errors++;
        $display("FAIL %s act=%h exp=%h",
                 t.name, act, t.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vt [12];

  initial begin
    vt[0]  = '{"add_carry_in", 2'b01,
               64'h8000_0000, 64'hFFFF_FFFF_FFFF_F800,
               64'h7FFF_F800};
    vt[1]  = '{"add_wrap", 2'b01,
               64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0};
    vt[2]  = '{"add_plain", 2'b01,
               64'h1234, 64'h0000_0001_0000_0000,
               64'h0000_0001_0000_1234};
    vt[3]  = '{"sltu_lt", 2'b10, 64'h1, 64'h2, 64'h1};
    vt[4]  = '{"sltu_big", 2'b10,
               64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0};
    vt[5]  = '{"sltu_eq", 2'b10, 64'h5, 64'h5, 64'h0};
    vt[6]  = '{"sltu_msb", 2'b10,
               64'h7FFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 64'h1};
    vt[7]  = '{"sltu_gt", 2'b10, 64'h3, 64'h2, 64'h0};
    vt[8]  = '{"op00", 2'b00, 64'h55, 64'hAA, 64'h0};
    vt[9]  = '{"op11", 2'b11, 64'h1, 64'h2, 64'h0};
    vt[10] = '{"op11_ltu", 2'b11, 64'h0, 64'h9, 64'h0};
    vt[11] = '{"op00_ones", 2'b00,
               64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFF, 64'h0};

    rst = 1'b1;
    bus.raddr1 = '0;
    bus.raddr2 = '0;
    bus.we = 1'b0;
    bus.waddr = '0;
    bus.wdata = '0;
    bus.alu_src1 = 64'h10;
    bus.alu_src2 = 64'h20;
    bus.aluop = 2'b01;
    #1;
    push("alu_during_reset", 64'h30);
    pop_cmp(bus.alu_result);
    step();
    rst = 1'b0;

    bus.raddr1 = 5'd7;
    push("reset_x7", 64'h0);
    #1 pop_cmp(bus.rdata1);

    for (int i = 0; i < 12; i++) begin
      bus.aluop = vt[i].op;
      bus.alu_src1 = vt[i].a;
      bus.alu_src2 = vt[i].b;
      push(vt[i].name, vt[i].exp);
      #1 pop_cmp(bus.alu_result);
    end

    // write x5 then clear via reset
    bus.we = 1'b1;
    bus.waddr = 5'd5;
    bus.wdata = 64'hDEAD_BEEF_0000_1111;
    step();
    bus.we = 1'b0;
    bus.raddr1 = 5'd5;
    push("x5_written", 64'hDEAD_BEEF_0000_1111);
    #1 pop_cmp(bus.rdata1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    push("x5_after_reset", 64'h0);
    #1 pop_cmp(bus.rdata1);
    for (int a = 1; a < 32; a++) begin
      bus.raddr2 = 5'(a);
      push($sformatf("clr_x%0d", a), 64'h0);
      #1 pop_cmp(bus.rdata2);
    end

    // x0 hard-wired
    bus.we = 1'b1;
    bus.waddr = 5'd0;
    bus.wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    bus.we = 1'b0;
    bus.raddr1 = 5'd0;
    bus.raddr2 = 5'd0;
    push("x0_p1", 64'h0);
    push("x0_p2", 64'h0);
    #1 pop_cmp(bus.rdata1);
    pop_cmp(bus.rdata2);

    // write latency, no bypass
    bus.raddr1 = 5'd10;
    bus.we = 1'b1;
    bus.waddr = 5'd10;
    bus.wdata = 64'h1234_5678_8765_4321;
    push("x10_no_bypass", 64'h0);
    #1 pop_cmp(bus.rdata1);
    step();
    bus.we = 1'b0;
    bus.raddr2 = 5'd10;
    push("x10_p1", 64'h1234_5678_8765_4321);
    push("x10_p2", 64'h1234_5678_8765_4321);
    #1 pop_cmp(bus.rdata1);
    pop_cmp(bus.rdata2);

    // reset overrides a concurrent write
    rst = 1'b1;
    bus.we = 1'b1;
    bus.waddr = 5'd3;
    bus.wdata = 64'h1;
    step();
    rst = 1'b0;
    bus.we = 1'b0;
    bus.raddr1 = 5'd3;
    bus.raddr2 = 5'd10;
    push("x3_write_in_reset", 64'h0);
    push("x10_cleared", 64'h0);
    #1 pop_cmp(bus.rdata1);
    pop_cmp(bus.rdata2);

    // first edge with rst low accepts a write
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.we = 1'b1;
    bus.waddr = 5'd3;
    bus.wdata = 64'h77;
    step();
    bus.we = 1'b0;
    push("x3_first_write", 64'h77);
    #1 pop_cmp(bus.rdata1);

    // random writes against a reference model
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    for (int i = 0; i < 40; i++) begin
      bus.we = ($urandom_range(0, 3) != 0);
      bus.waddr = 5'($urandom_range(0, 31));
      bus.wdata = {$urandom, $urandom};
      step();
      if (bus.we && bus.waddr != 0)
        model[bus.waddr] = bus.wdata;
    end
    bus.we = 1'b0;
    for (int a = 0; a < 32; a++) begin
      bus.raddr1 = 5'(a);
      bus.raddr2 = 5'(31 - a);
      push($sformatf("rnd_p1_x%0d", a), model[a]);
      push($sformatf("rnd_p2_x%0d", 31 - a),
           model[31 - a]);
      #1 pop_cmp(bus.rdata1);
      pop_cmp(bus.rdata2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
